// File: rtl/serial_config_transfer_ctrl.sv
// rtl/serial_config_transfer_ctrl.sv - two-wire write sequencer driven by slow-clock generator strobes
//
// Purpose: sends DATA_BYTES bytes (MS byte first, each byte MSB first) as one
// two-wire write transaction. Checks the ACK after each byte and aborts to STOP
// on a NACK.
//
// Ports:
//   clk, reset_n              system clock, asynchronous active-low reset
//   start, data_in            transfer request and the bytes to send
//   clk_rising_edge,
//   clk_falling_edge,
//   clk_mid_high, clk_mid_low slow-clock generator strobes (one clk wide)
//   sda_in                    sampled bus data line
//   enable_clk                runs the generator while a transfer is active
//   scl, sda_out, sda_oe      bus clock, data value, data drive enable
//   busy, done, ack_error     status to the configuration ROM walker

module serial_config_transfer_ctrl #(
   parameter int DATA_BYTES = 3
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [8*DATA_BYTES-1:0] data_in,
   input  logic                    clk_rising_edge,
   input  logic                    clk_falling_edge,
   input  logic                    clk_mid_high,
   input  logic                    clk_mid_low,
   input  logic                    sda_in,
   output logic                    enable_clk,
   output logic                    scl,
   output logic                    sda_out,
   output logic                    sda_oe,
   output logic                    busy,
   output logic                    done,
   output logic                    ack_error
);

   localparam int W = 8 * DATA_BYTES;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_FINISH
   } state_t;

   state_t         state;
   state_t         state_nx;
   logic [W-1:0]   shift_reg;
   logic [3:0]     bit_cnt;
   logic [2:0]     byte_cnt;
   logic           last_byte;

   // byte_cnt is incremented on the falling edge that leaves ACK, so the byte
   // being acknowledged is the last one when the count is one short.
   assign last_byte = (byte_cnt == 3'(DATA_BYTES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (start) state_nx = S_START;
         // sda_out low means the start condition is already on the bus; a
         // falling strobe arriving before it must not end the START phase.
         S_START:  if (clk_falling_edge && !sda_out) state_nx = S_BIT;
         S_BIT:    if (clk_falling_edge && bit_cnt == 4'd8) state_nx = S_ACK;
         S_ACK:    if (clk_falling_edge) state_nx = (ack_error || last_byte) ? S_STOP : S_BIT;
         S_STOP:   if (clk_mid_high) state_nx = S_FINISH;
         S_FINISH: state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scl        <= 1'b1;
         sda_out    <= 1'b1;
         sda_oe     <= 1'b1;
         enable_clk <= 1'b0;
         busy       <= 1'b0;
         ack_error  <= 1'b0;
         bit_cnt    <= '0;
         byte_cnt   <= '0;
         shift_reg  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  shift_reg  <= data_in;
                  ack_error  <= 1'b0;
                  bit_cnt    <= '0;
                  byte_cnt   <= '0;
                  busy       <= 1'b1;
                  enable_clk <= 1'b1;
               end
            end
            S_START: begin
               if (clk_mid_high) sda_out <= 1'b0;
               if (clk_falling_edge && !sda_out) scl <= 1'b0;
            end
            S_BIT: begin
               // Re-taking the line here covers the return from an ACK slot.
               if (clk_mid_low) begin
                  sda_oe    <= 1'b1;
                  sda_out   <= shift_reg[W-1];
                  shift_reg <= shift_reg << 1;
                  bit_cnt   <= bit_cnt + 4'd1;
               end
               if (clk_rising_edge)  scl <= 1'b1;
               if (clk_falling_edge) scl <= 1'b0;
            end
            S_ACK: begin
               if (clk_mid_low)             sda_oe    <= 1'b0;
               if (clk_rising_edge)         scl       <= 1'b1;
               if (clk_mid_high && sda_in)  ack_error <= 1'b1;
               if (clk_falling_edge) begin
                  scl      <= 1'b0;
                  bit_cnt  <= '0;
                  byte_cnt <= byte_cnt + 3'd1;
               end
            end
            S_STOP: begin
               if (clk_mid_low) begin
                  sda_oe  <= 1'b1;
                  sda_out <= 1'b0;
               end
               if (clk_rising_edge) scl     <= 1'b1;
               if (clk_mid_high)    sda_out <= 1'b1;
            end
            S_FINISH: begin
               busy       <= 1'b0;
               enable_clk <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      done = (state == S_FINISH);
   end

endmodule

// File: tb/tb_serial_config_transfer_ctrl.sv
// tb/tb_serial_config_transfer_ctrl.sv - self-checking bench for serial_config_transfer_ctrl
module tb_serial_config_transfer_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;

   // Free-running generator model, 16 clk slow period.
   logic [3:0] gen_cnt = 4'd0;
   always @(posedge clk) gen_cnt <= gen_cnt + 4'd1;
   logic st_rise, st_fall, st_mhigh, st_mlow;
   assign st_rise  = (gen_cnt == 4'd0);
   assign st_mhigh = (gen_cnt == 4'd4);
   assign st_fall  = (gen_cnt == 4'd8);
   assign st_mlow  = (gen_cnt == 4'd12);

   // Three-byte instance
   logic        start_a, sda_in_a, enable_clk_a, scl_a, sda_out_a, sda_oe_a;
   logic        busy_a, done_a, ack_error_a;
   logic [23:0] data_a;
   // One-byte instance
   logic        start_b, sda_in_b, enable_clk_b, scl_b, sda_out_b, sda_oe_b;
   logic        busy_b, done_b, ack_error_b;
   logic [7:0]  data_b;

   serial_config_transfer_ctrl #(.DATA_BYTES(3)) dut_a (
      .clk(clk), .reset_n(reset_n), .start(start_a), .data_in(data_a),
      .clk_rising_edge(st_rise), .clk_falling_edge(st_fall),
      .clk_mid_high(st_mhigh), .clk_mid_low(st_mlow), .sda_in(sda_in_a),
      .enable_clk(enable_clk_a), .scl(scl_a), .sda_out(sda_out_a), .sda_oe(sda_oe_a),
      .busy(busy_a), .done(done_a), .ack_error(ack_error_a));

   serial_config_transfer_ctrl #(.DATA_BYTES(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .start(start_b), .data_in(data_b),
      .clk_rising_edge(st_rise), .clk_falling_edge(st_fall),
      .clk_mid_high(st_mhigh), .clk_mid_low(st_mlow), .sda_in(sda_in_b),
      .enable_clk(enable_clk_b), .scl(scl_b), .sda_out(sda_out_b), .sda_oe(sda_oe_b),
      .busy(busy_b), .done(done_b), .ack_error(ack_error_b));

   // Slave model: each release of the line opens the next ACK slot.
   logic [2:0] nack_mask;
   int         ack_idx = 0;
   int         ack_base = 0;
   logic       cur_nack = 1'b0;
   always @(negedge sda_oe_a) begin
      cur_nack <= ((ack_idx - ack_base) < 3) ? nack_mask[ack_idx - ack_base] : 1'b0;
      ack_idx  <= ack_idx + 1;
   end
   assign sda_in_a = sda_oe_a ? 1'b1 : cur_nack;
   assign sda_in_b = sda_oe_b ? 1'b1 : 1'b0;

   // Bus monitor: bits captured on scl rising, start/stop = sda edge while scl high.
   logic [1:0] scl_v, line_v, done_v, p_scl, p_line;
   assign scl_v  = {scl_b, scl_a};
   assign line_v = {sda_oe_b ? sda_out_b : sda_in_b, sda_oe_a ? sda_out_a : sda_in_a};
   assign done_v = {done_b, done_a};
   logic        mon_clr;
   logic [63:0] bits   [2];
   int          nbits  [2];
   int          starts [2];
   int          stops  [2];
   int          dones  [2];

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (mon_clr) begin
            bits[d] <= '0; nbits[d] <= 0; starts[d] <= 0; stops[d] <= 0; dones[d] <= 0;
         end else begin
            if (scl_v[d] && !p_scl[d] && nbits[d] < 64) begin
               bits[d][nbits[d][5:0]] <= line_v[d];
               nbits[d] <= nbits[d] + 1;
            end
            if (scl_v[d] && p_scl[d] && line_v[d] != p_line[d]) begin
               if (line_v[d]) stops[d]  <= stops[d] + 1;
               else           starts[d] <= starts[d] + 1;
            end
            if (done_v[d]) dones[d] <= dones[d] + 1;
         end
      end
      p_scl  <= scl_v;
      p_line <= line_v;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] get_byte(input int d, input int k);
      logic [63:0] t;
      logic [7:0]  r;
      t = bits[d] >> (9 * k);
      r = {<<{t[7:0]}};
      return r;
   endfunction

   function automatic logic get_ack(input int d, input int k);
      logic [63:0] t;
      t = bits[d] >> (9 * k);
      return t[8];
   endfunction

   task automatic clear_mon(input logic [2:0] mask);
      @(posedge clk);
      mon_clr   = 1'b1;
      nack_mask = mask;
      ack_base  = ack_idx;
      @(posedge clk);
      mon_clr = 1'b0;
   endtask

   task automatic launch_a(input logic [23:0] d, input logic [2:0] mask);
      clear_mon(mask);
      @(negedge clk);
      data_a  = d;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      chk("start_busy", busy_a, 1'b1);
      chk("start_enable_clk", enable_clk_a, 1'b1);
      chk("start_ack_error_clear", ack_error_a, 1'b0);
   endtask

   task automatic wait_done(input int d);
      int n;
      n = 0;
      while (!(d == 0 ? done_a : done_b) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("done_seen_dut%0d", d), (d == 0 ? done_a : done_b), 1'b1);
   endtask

   task automatic wait_bits(input int d, input int target);
      int n;
      n = 0;
      while (nbits[d] < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("bits_reached", (nbits[d] >= target), 1'b1);
   endtask

   task automatic check_bytes(input string tag, input logic [23:0] d, input int nsent,
                              input logic [2:0] mask);
      chk({tag, "_nbits"}, nbits[0], 9 * nsent + 1);
      for (int k = 0; k < nsent; k++) begin
         chk($sformatf("%s_byte%0d", tag, k), get_byte(0, k), (d >> (16 - 8 * k)) & 24'hFF);
         chk($sformatf("%s_ack%0d", tag, k), get_ack(0, k), mask[k]);
      end
      chk({tag, "_starts"}, starts[0], 1);
      chk({tag, "_stops"}, stops[0], 1);
      chk({tag, "_dones"}, dones[0], 1);
   endtask

   typedef struct {
      logic [23:0] data;
      logic [2:0]  nack;
      int          nsent;
      logic        err;
   } vec_t;
   vec_t vecs [5];

   initial begin
      int bad;
      reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
      data_a = '0; data_b = '0; mon_clr = 1'b0; nack_mask = '0;

      vecs[0] = '{24'h341E97, 3'b000, 3, 1'b0};
      vecs[1] = '{24'h341E97, 3'b010, 2, 1'b1};
      vecs[2] = '{24'hA5C300, 3'b001, 1, 1'b1};
      vecs[3] = '{24'hFF00A5, 3'b100, 3, 1'b1};
      vecs[4] = '{24'h5A0F81, 3'b000, 3, 1'b0};

      repeat (3) @(negedge clk);
      chk("rst_scl", scl_a, 1'b1);
      chk("rst_sda_out", sda_out_a, 1'b1);
      chk("rst_sda_oe", sda_oe_a, 1'b1);
      chk("rst_enable_clk", enable_clk_a, 1'b0);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_done", done_a, 1'b0);
      chk("rst_ack_error", ack_error_a, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("release_busy", busy_a, 1'b0);

      for (int v = 0; v < 5; v++) begin
         launch_a(vecs[v].data, vecs[v].nack);
         wait_done(0);
         repeat (3) @(negedge clk);
         check_bytes($sformatf("v%0d", v), vecs[v].data, vecs[v].nsent, vecs[v].nack);
         chk($sformatf("v%0d_ack_error", v), ack_error_a, vecs[v].err);
         chk($sformatf("v%0d_busy_after", v), busy_a, 1'b0);
         chk($sformatf("v%0d_enable_after", v), enable_clk_a, 1'b0);
      end

      // start while busy must not re-latch data_in
      launch_a(24'h341E97, 3'b000);
      wait_bits(0, 3);
      @(negedge clk);
      data_a  = 24'hFFFFFF;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wait_done(0);
      repeat (60) @(negedge clk);
      check_bytes("restart", 24'h341E97, 3, 3'b000);

      // start coinciding with the done cycle is dropped
      launch_a(24'h123456, 3'b000);
      wait_done(0);
      data_a  = 24'hABCDEF;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      chk("finish_start_busy", busy_a, 1'b0);
      repeat (4) @(negedge clk);
      chk("finish_start_busy_later", busy_a, 1'b0);
      chk("finish_start_enable", enable_clk_a, 1'b0);

      // reset during bit 5 of byte 2
      launch_a(24'h341E97, 3'b000);
      wait_bits(0, 14);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_scl", scl_a, 1'b1);
      chk("midrst_sda_out", sda_out_a, 1'b1);
      chk("midrst_sda_oe", sda_oe_a, 1'b1);
      chk("midrst_busy", busy_a, 1'b0);
      chk("midrst_enable", enable_clk_a, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("midrst_no_done", dones[0], 0);
      launch_a(24'h341E97, 3'b000);
      wait_done(0);
      repeat (3) @(negedge clk);
      check_bytes("after_rst", 24'h341E97, 3, 3'b000);
      chk("after_rst_ack_error", ack_error_a, 1'b0);

      // one-byte instance
      clear_mon(3'b000);
      chk("b_enable_before", enable_clk_b, 1'b0);
      @(negedge clk);
      data_b  = 8'hA5;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      chk("b_enable_active", enable_clk_b, 1'b1);
      wait_done(1);
      repeat (3) @(negedge clk);
      chk("b_nbits", nbits[1], 10);
      chk("b_byte", get_byte(1, 0), 8'hA5);
      chk("b_ack", get_ack(1, 0), 1'b0);
      chk("b_starts", starts[1], 1);
      chk("b_stops", stops[1], 1);
      chk("b_dones", dones[1], 1);
      chk("b_ack_error", ack_error_b, 1'b0);
      chk("b_enable_after", enable_clk_b, 1'b0);
      chk("b_busy_after", busy_b, 1'b0);

      // strobes keep running while both instances sit idle
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (scl_a !== 1'b1 || sda_out_a !== 1'b1 || sda_oe_a !== 1'b1 || busy_a !== 1'b0) bad++;
         if (scl_b !== 1'b1 || sda_out_b !== 1'b1 || sda_oe_b !== 1'b1 || busy_b !== 1'b0) bad++;
      end
      chk("idle_hold", bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
